// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave framing FSM: MOSI deserialiser and MISO read-data serialiser
// Optional macro SPI_FRAME_ERR_EN adds the frame_err abort strobe.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   SS_n,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic [ADDR_SIZE+1:0]   rx_din,
  output logic                   rx_valid,
  input  logic [ADDR_SIZE-1:0]   tx_dout,
  input  logic                   tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                   frame_err
`endif
);

  localparam int FRAME = ADDR_SIZE + 2;
  localparam int CW    = $clog2(FRAME + 1);
  localparam int TCW   = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FRAME-1:0]     rx_shift_q, rx_shift_d;
  logic [FRAME-1:0]     rx_din_q, rx_din_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_addr_done_q, rd_addr_done_d;
  logic [ADDR_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 miso_q, miso_d;
`ifdef SPI_FRAME_ERR_EN
  logic                 frame_err_q, frame_err_d;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rx_shift_d     = rx_shift_q;
    rx_din_d       = rx_din_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    tx_busy_d      = tx_busy_q;
    tx_done_d      = tx_done_q;
    miso_d         = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    frame_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)                state_d = IDLE;
        else if (!MOSI)          state_d = WRITE;
        else if (rd_addr_done_q) state_d = READ_DATA;
        else                     state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) begin
          // Abort: partial frame dropped, shift killed, rd_addr_done kept.
          state_d   = IDLE;
          cnt_d     = '0;
          tx_busy_d = 1'b0;
          tx_done_d = 1'b0;
`ifdef SPI_FRAME_ERR_EN
          frame_err_d = (cnt_q < CW'(FRAME)) || tx_busy_q;
`endif
        end else if (cnt_q != CW'(FRAME)) begin
          rx_shift_d = {rx_shift_q[FRAME-2:0], MOSI};
          cnt_d      = cnt_q + CW'(1);
          if (cnt_q == CW'(FRAME - 1)) begin
            rx_din_d   = {rx_shift_q[FRAME-2:0], MOSI};
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
          end
        end else if (state_q == READ_DATA) begin
          if (tx_busy_q) begin
            if (tx_cnt_q != '0) begin
              miso_d     = tx_shift_q[ADDR_SIZE-1];
              tx_shift_d = {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
              tx_cnt_d   = tx_cnt_q - TCW'(1);
            end else begin
              tx_busy_d      = 1'b0;
              tx_done_d      = 1'b1;
              rd_addr_done_d = 1'b0;
            end
          end else if (!tx_done_q && tx_valid) begin
            // MSB goes out on the cycle right after the latch.
            miso_d     = tx_dout[ADDR_SIZE-1];
            tx_shift_d = {tx_dout[ADDR_SIZE-2:0], 1'b0};
            tx_cnt_d   = TCW'(ADDR_SIZE - 1);
            tx_busy_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rx_shift_q     <= '0;
      rx_din_q       <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      miso_q         <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rx_shift_q     <= rx_shift_d;
      rx_din_q       <= rx_din_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_busy_q      <= tx_busy_d;
      tx_done_q      <= tx_done_d;
      miso_q         <= miso_d;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q    <= frame_err_d;
`endif
    end
  end

  assign MISO     = miso_q;
  assign rx_din   = rx_din_q;
  assign rx_valid = rx_valid_q;
`ifdef SPI_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - directed self-checking bench for spi_slave_if
// Covers write/read frames, MISO return, aborts and async reset.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_din;
  logic       rx_valid;
  logic [7:0] tx_dout;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_CHK = 3'd1, S_WRITE = 3'd2,
                         S_RADD = 3'd3, S_RDATA = 3'd4;

  spi_slave_if #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_din   (rx_din),
    .rx_valid (rx_valid),
    .tx_dout  (tx_dout),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full frame: select bit then 10 data bits MSB first; checks the rx_valid strobe.
  task automatic send_frame(input logic sel, input logic [9:0] word, input logic [2:0] exp_state);
    SS_n = 1'b0;
    cyc();
    chk("chk_cmd_state", 32'(dut.state_q), 32'(S_CHK));
    MOSI = sel;
    cyc();
    chk("frame_state", 32'(dut.state_q), 32'(exp_state));
    for (int i = 9; i >= 0; i--) begin
      MOSI = word[i];
      cyc();
      if (i > 0) chk("rx_valid_early", 32'(rx_valid), 32'd0);
    end
    chk("rx_valid_pulse", 32'(rx_valid), 32'd1);
    chk("rx_din", 32'(rx_din), 32'(word));
    MOSI = 1'b0;
    cyc();
    chk("rx_valid_single", 32'(rx_valid), 32'd0);
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    cyc();
    chk("idle_after_ss", 32'(dut.state_q), 32'(S_IDLE));
  endtask

  initial begin
    logic [7:0] tx_bits;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_dout = 8'h00; tx_valid = 1'b0;
    #12;
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_rx_din", 32'(rx_din), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    rst_n = 1'b1;
    cyc();
    chk("idle_hold", 32'(dut.state_q), 32'(S_IDLE));

    // Write address, then extra MOSI bits with SS_n still low are ignored.
    send_frame(1'b0, 10'h0A5, S_WRITE);
    chk("write_miso", 32'(MISO), 32'd0);
    for (int i = 0; i < 4; i++) begin
      MOSI = ~MOSI;
      cyc();
      chk("extra_bits_no_valid", 32'(rx_valid), 32'd0);
    end
    chk("write_state_hold", 32'(dut.state_q), 32'(S_WRITE));
    chk("extra_bits_rx_din", 32'(rx_din), 32'h0A5);
    end_frame();

    send_frame(1'b0, 10'h13C, S_WRITE);
    chk("wr_data_rd_done", 32'(dut.rd_addr_done_q), 32'd0);
    end_frame();

    // Read address then read data with MISO return of 8'hC3.
    send_frame(1'b1, 10'h207, S_RADD);
    chk("rd_done_set", 32'(dut.rd_addr_done_q), 32'd1);
    end_frame();
    send_frame(1'b1, 10'h300, S_RDATA);
    chk("miso_wait", 32'(MISO), 32'd0);
    tx_dout = 8'hC3; tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    tx_bits = 8'hC3;
    chk("miso_b7", 32'(MISO), 32'(tx_bits[7]));
    for (int i = 6; i >= 0; i--) begin
      tx_valid = (i == 4);
      tx_dout = 8'h5A;
      cyc();
      chk("miso_bit", 32'(MISO), 32'(tx_bits[i]));
    end
    tx_valid = 1'b0;
    cyc();
    chk("miso_after", 32'(MISO), 32'd0);
    chk("rd_done_clear", 32'(dut.rd_addr_done_q), 32'd0);
    tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    chk("no_second_shift", 32'(MISO), 32'd0);
    chk("rdata_hold", 32'(dut.state_q), 32'(S_RDATA));
    end_frame();

    // Abort after 5 data bits.
    SS_n = 1'b0; cyc();
    MOSI = 1'b0; cyc();
    for (int i = 0; i < 5; i++) begin MOSI = 1'b1; cyc(); end
    SS_n = 1'b1;
    cyc();
`ifdef SPI_FRAME_ERR_EN
    chk("frame_err_pulse", 32'(frame_err), 32'd1);
`endif
    chk("abort_no_valid", 32'(rx_valid), 32'd0);
    chk("abort_rx_din", 32'(rx_din), 32'h300);
    chk("abort_idle", 32'(dut.state_q), 32'(S_IDLE));
    cyc();
    chk("abort_no_late_valid", 32'(rx_valid), 32'd0);

    // SS_n rises on the cycle the last bit would be sampled.
    SS_n = 1'b0; cyc();
    MOSI = 1'b0; cyc();
    for (int i = 0; i < 9; i++) begin MOSI = 1'b1; cyc(); end
    SS_n = 1'b1;
    cyc();
    chk("lastbit_abort_valid", 32'(rx_valid), 32'd0);
    chk("lastbit_abort_rx_din", 32'(rx_din), 32'h300);

    // Abort a MISO shift: rd_addr_done must stay set.
    send_frame(1'b1, 10'h211, S_RADD);
    end_frame();
    send_frame(1'b1, 10'h3FF, S_RDATA);
    tx_dout = 8'hFF; tx_valid = 1'b1; cyc(); tx_valid = 1'b0;
    cyc();
    chk("shift_active", 32'(MISO), 32'd1);
    SS_n = 1'b1;
    cyc();
    chk("shift_abort_miso", 32'(MISO), 32'd0);
    chk("shift_abort_rd_done", 32'(dut.rd_addr_done_q), 32'd1);
    chk("shift_abort_idle", 32'(dut.state_q), 32'(S_IDLE));

    // Async reset mid-shift, between clock edges.
    send_frame(1'b1, 10'h3AA, S_RDATA);
    tx_dout = 8'hFF; tx_valid = 1'b1; cyc(); tx_valid = 1'b0;
    cyc(); cyc();
    chk("pre_reset_miso", 32'(MISO), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_miso", 32'(MISO), 32'd0);
    chk("async_rst_valid", 32'(rx_valid), 32'd0);
    chk("async_rst_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("async_rst_rx_din", 32'(rx_din), 32'd0);
    SS_n = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();
    send_frame(1'b1, 10'h2C3, S_RADD);
    end_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
